// File: rtl/final_logic.sv
// ---------------------------------------------------------------------------
// final_logic
//   Egress end of the transmission-layer virtual-channel path. Drains the
//   VC0/VC1 FIFOs filled by the ingress logic, gives VC0 strict priority, and
//   routes every word to destination FIFO D0 (bit 4 = 0) or D1 (bit 4 = 1).
//   Downstream almost-full on either destination pauses new pops. Keeps a
//   wrapping word counter per destination and an idle flag for the
//   transmission-layer controller.
//
// Ports
//   clk             system clock, rising edge
//   reset           asynchronous active-low reset (0 = in reset)
//   init            1 = hold / return to INIT, no new pops
//   empty_fifo_VC0  VC0 FIFO empty
//   empty_fifo_VC1  VC1 FIFO empty
//   data_out_VC0    VC0 FIFO read data, valid the cycle after a pop
//   data_out_VC1    VC1 FIFO read data, valid the cycle after a pop
//   almost_full_D0  destination D0 almost full
//   almost_full_D1  destination D1 almost full
//   pop_VC0_fifo    pop request to VC0 (combinational)
//   pop_VC1_fifo    pop request to VC1 (combinational)
//   data_out        word pushed to the destination FIFOs (registered)
//   push_D0         write strobe for D0 (registered)
//   push_D1         write strobe for D1 (registered)
//   count_D0        words pushed to D0, wraps
//   count_D1        words pushed to D1, wraps
//   idle            1 while in IDLE (registered)
//   state           FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3
// ---------------------------------------------------------------------------
module final_logic #(
    parameter int data_width  = 6,
    parameter int count_width = 5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   init,
    input  logic                   empty_fifo_VC0,
    input  logic                   empty_fifo_VC1,
    input  logic [data_width-1:0]  data_out_VC0,
    input  logic [data_width-1:0]  data_out_VC1,
    input  logic                   almost_full_D0,
    input  logic                   almost_full_D1,
    output logic                   pop_VC0_fifo,
    output logic                   pop_VC1_fifo,
    output logic [data_width-1:0]  data_out,
    output logic                   push_D0,
    output logic                   push_D1,
    output logic [count_width-1:0] count_D0,
    output logic [count_width-1:0] count_D1,
    output logic                   idle,
    output logic [1:0]             state
);

    // Bit of the word that selects the destination FIFO.
    localparam int DEST_BIT = 4;

    localparam logic [count_width-1:0] CNT_ZERO = {count_width{1'b0}};
    localparam logic [count_width-1:0] CNT_ONE  = {{(count_width-1){1'b0}}, 1'b1};
    localparam logic [data_width-1:0]  DATA_ZERO = {data_width{1'b0}};

    typedef enum logic [1:0] {
        ST_RESET  = 2'd0,
        ST_INIT   = 2'd1,
        ST_IDLE   = 2'd2,
        ST_ACTIVE = 2'd3
    } state_t;

    state_t                 r_state;
    state_t                 w_next_state;

    logic                   w_pause;
    logic                   w_pop_vc0;
    logic                   w_pop_vc1;
    logic                   w_pop_any;

    // Read pipeline: a pop in cycle N marks the data valid in cycle N+1.
    logic                   r_rd_valid;
    logic                   r_rd_src;
    logic [data_width-1:0]  w_rd_word;
    logic                   w_rd_dest;

    logic [data_width-1:0]  r_data_out;
    logic                   r_push_d0;
    logic                   r_push_d1;
    logic [count_width-1:0] r_count_d0;
    logic [count_width-1:0] r_count_d1;
    logic                   r_idle;

    // The destination of a word is unknown until it is read, so either
    // almost-full flag stops all new pops.
    assign w_pause = almost_full_D0 | almost_full_D1;

    // Pop decision: VC0 strict priority, at most one pop per cycle.
    always_comb begin
        w_pop_vc0 = 1'b0;
        w_pop_vc1 = 1'b0;
        if ((r_state == ST_ACTIVE) && !init && !w_pause) begin
            w_pop_vc0 = !empty_fifo_VC0;
            w_pop_vc1 = empty_fifo_VC0 & !empty_fifo_VC1;
        end else begin
            w_pop_vc0 = 1'b0;
            w_pop_vc1 = 1'b0;
        end
    end

    assign w_pop_any = w_pop_vc0 | w_pop_vc1;

    // Next-state logic; init always wins over pending FIFO traffic.
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_RESET: begin
                w_next_state = ST_INIT;
            end
            ST_INIT: begin
                // Leave INIT only once the in-flight word has been pushed.
                if (!init && !r_rd_valid) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_INIT;
                end
            end
            ST_IDLE: begin
                if (init) begin
                    w_next_state = ST_INIT;
                end else if (!empty_fifo_VC0 || !empty_fifo_VC1) begin
                    w_next_state = ST_ACTIVE;
                end else begin
                    w_next_state = ST_IDLE;
                end
            end
            ST_ACTIVE: begin
                if (init) begin
                    w_next_state = ST_INIT;
                end else if (empty_fifo_VC0 && empty_fifo_VC1 && !w_pop_any && !r_rd_valid) begin
                    w_next_state = ST_IDLE;
                end else begin
                    w_next_state = ST_ACTIVE;
                end
            end
            default: begin
                w_next_state = ST_RESET;
            end
        endcase
    end

    // State register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_RESET;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Read pipeline stage: remember that a pop happened and from which VC.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_rd_valid <= 1'b0;
            r_rd_src   <= 1'b0;
        end else begin
            r_rd_valid <= w_pop_any;
            if (w_pop_any) begin
                r_rd_src <= w_pop_vc1;
            end else begin
                r_rd_src <= r_rd_src;
            end
        end
    end

    assign w_rd_word = r_rd_src ? data_out_VC1 : data_out_VC0;
    assign w_rd_dest = w_rd_word[DEST_BIT];

    // Push stage: a popped word is always pushed, even if a pause arrived
    // meanwhile; the almost-full margin absorbs it.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_data_out <= DATA_ZERO;
            r_push_d0  <= 1'b0;
            r_push_d1  <= 1'b0;
            r_count_d0 <= CNT_ZERO;
            r_count_d1 <= CNT_ZERO;
        end else if (r_rd_valid) begin
            r_data_out <= w_rd_word;
            r_push_d0  <= !w_rd_dest;
            r_push_d1  <= w_rd_dest;
            if (w_rd_dest) begin
                r_count_d1 <= r_count_d1 + CNT_ONE;
            end else begin
                r_count_d0 <= r_count_d0 + CNT_ONE;
            end
        end else begin
            r_push_d0 <= 1'b0;
            r_push_d1 <= 1'b0;
        end
    end

    // Idle flag registered from the next state so it tracks state exactly.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_idle <= 1'b0;
        end else begin
            r_idle <= (w_next_state == ST_IDLE);
        end
    end

    assign pop_VC0_fifo = w_pop_vc0;
    assign pop_VC1_fifo = w_pop_vc1;
    assign data_out     = r_data_out;
    assign push_D0      = r_push_d0;
    assign push_D1      = r_push_d1;
    assign count_D0     = r_count_d0;
    assign count_D1     = r_count_d1;
    assign idle         = r_idle;
    assign state        = r_state;

endmodule

// File: tb/tb_final_logic.sv
// ---------------------------------------------------------------------------
// tb_final_logic
//   Self-checking bench for final_logic: a directed vector table for the
//   reset/init/first-transfer sequence, hand-written corner sequences, and a
//   randomized phase, all compared against a queue-based reference model.
// ---------------------------------------------------------------------------
module tb_final_logic;

    logic       clk;
    logic       reset;
    logic       init;
    logic       empty_fifo_VC0;
    logic       empty_fifo_VC1;
    logic [5:0] data_out_VC0;
    logic [5:0] data_out_VC1;
    logic       almost_full_D0;
    logic       almost_full_D1;
    logic       pop_VC0_fifo;
    logic       pop_VC1_fifo;
    logic [5:0] data_out;
    logic       push_D0;
    logic       push_D1;
    logic [4:0] count_D0;
    logic [4:0] count_D1;
    logic       idle;
    logic [1:0] state;

    final_logic #(.data_width(6), .count_width(5)) dut (
        .clk(clk), .reset(reset), .init(init),
        .empty_fifo_VC0(empty_fifo_VC0), .empty_fifo_VC1(empty_fifo_VC1),
        .data_out_VC0(data_out_VC0), .data_out_VC1(data_out_VC1),
        .almost_full_D0(almost_full_D0), .almost_full_D1(almost_full_D1),
        .pop_VC0_fifo(pop_VC0_fifo), .pop_VC1_fifo(pop_VC1_fifo),
        .data_out(data_out), .push_D0(push_D0), .push_D1(push_D1),
        .count_D0(count_D0), .count_D1(count_D1),
        .idle(idle), .state(state)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    // Source FIFO contents (what the ingress side has written).
    logic [5:0] q0[$];
    logic [5:0] q1[$];

    // Reference model: mode 0=RESET 1=INIT 2=IDLE 3=ACTIVE, plus the word
    // that has been read out of a FIFO but not yet delivered.
    int         m_state;
    bit         m_have;
    logic [5:0] m_word;
    logic [5:0] m_d;
    bit         m_p0;
    bit         m_p1;
    int         m_c0;
    int         m_c1;

    logic obs_pop0;
    logic obs_pop1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_state = 0;
        m_have  = 1'b0;
        m_word  = 6'h00;
        m_d     = 6'h00;
        m_p0    = 1'b0;
        m_p1    = 1'b0;
        m_c0    = 0;
        m_c1    = 0;
    endtask

    // One clock cycle: starts just after a falling edge with inputs set,
    // ends at the next falling edge after checking all outputs.
    task automatic cycle();
        bit p0;
        bit p1;
        bit go;
        int ns;
        empty_fifo_VC0 = (q0.size() == 0);
        empty_fifo_VC1 = (q1.size() == 0);
        #1;
        go = reset && (m_state == 3) && !init && !(almost_full_D0 || almost_full_D1);
        p0 = go && (q0.size() != 0);
        p1 = go && (q0.size() == 0) && (q1.size() != 0);
        obs_pop0 = pop_VC0_fifo;
        obs_pop1 = pop_VC1_fifo;
        check("pop_VC0", obs_pop0, p0);
        check("pop_VC1", obs_pop1, p1);
        if (!reset) begin
            model_reset();
        end else begin
            ns = m_state;
            case (m_state)
                0: ns = 1;
                1: ns = (!init && !m_have) ? 2 : 1;
                2: ns = init ? 1 : ((q0.size() != 0 || q1.size() != 0) ? 3 : 2);
                3: ns = init ? 1 : ((q0.size() == 0 && q1.size() == 0 && !m_have) ? 2 : 3);
                default: ns = 0;
            endcase
            if (m_have) begin
                m_d  = m_word;
                m_p0 = !m_word[4];
                m_p1 = m_word[4];
                if (m_word[4]) m_c1 = (m_c1 + 1) % 32;
                else           m_c0 = (m_c0 + 1) % 32;
            end else begin
                m_p0 = 1'b0;
                m_p1 = 1'b0;
            end
            m_have = p0 || p1;
            if (p0)      m_word = q0[0];
            else if (p1) m_word = q1[0];
            m_state = ns;
        end
        @(posedge clk);
        #1;
        if (p0) data_out_VC0 = q0.pop_front();
        else    data_out_VC0 = 6'($urandom);
        if (p1) data_out_VC1 = q1.pop_front();
        else    data_out_VC1 = 6'($urandom);
        @(negedge clk);
        check("state", state, m_state);
        check("idle", idle, (m_state == 2));
        check("push_D0", push_D0, m_p0);
        check("push_D1", push_D1, m_p1);
        check("data_out", data_out, m_d);
        check("count_D0", count_D0, m_c0);
        check("count_D1", count_D1, m_c1);
    endtask

    task automatic run_until_idle(input int budget);
        int n;
        n = 0;
        do begin
            cycle();
            n++;
        end while (!(m_state == 2 && q0.size() == 0 && q1.size() == 0 && !m_have) && n < budget);
        check("drain_timeout", (n < budget), 1'b1);
    endtask

    task automatic reinit();
        reset = 1'b0; init = 1'b1;
        repeat (2) cycle();
        reset = 1'b1;
        cycle();
        init = 1'b0;
        cycle();
    endtask

    typedef struct {
        bit         rst;
        bit         ini;
        int         nadd;
        logic [5:0] w0;
        logic [5:0] w1;
        bit         e_pop0;
        logic [1:0] e_st;
        bit         e_p0;
        bit         e_p1;
        logic [5:0] e_d;
        logic [4:0] e_c0;
        logic [4:0] e_c1;
    } vec_t;

    vec_t       tbl[12];
    logic [5:0] words[$];
    bit         dests[$];
    int         npop;
    int         npush;

    initial begin
        tbl[0]  = '{1'b0, 1'b1, 0, 6'h00, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 6'h00, 5'd0, 5'd0};
        tbl[1]  = '{1'b0, 1'b1, 0, 6'h00, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 6'h00, 5'd0, 5'd0};
        tbl[2]  = '{1'b0, 1'b1, 0, 6'h00, 6'h00, 1'b0, 2'd0, 1'b0, 1'b0, 6'h00, 5'd0, 5'd0};
        tbl[3]  = '{1'b1, 1'b1, 0, 6'h00, 6'h00, 1'b0, 2'd1, 1'b0, 1'b0, 6'h00, 5'd0, 5'd0};
        tbl[4]  = '{1'b1, 1'b1, 0, 6'h00, 6'h00, 1'b0, 2'd1, 1'b0, 1'b0, 6'h00, 5'd0, 5'd0};
        tbl[5]  = '{1'b1, 1'b0, 0, 6'h00, 6'h00, 1'b0, 2'd2, 1'b0, 1'b0, 6'h00, 5'd0, 5'd0};
        tbl[6]  = '{1'b1, 1'b0, 2, 6'h01, 6'h12, 1'b0, 2'd3, 1'b0, 1'b0, 6'h00, 5'd0, 5'd0};
        tbl[7]  = '{1'b1, 1'b0, 0, 6'h00, 6'h00, 1'b1, 2'd3, 1'b0, 1'b0, 6'h00, 5'd0, 5'd0};
        tbl[8]  = '{1'b1, 1'b0, 0, 6'h00, 6'h00, 1'b1, 2'd3, 1'b1, 1'b0, 6'h01, 5'd1, 5'd0};
        tbl[9]  = '{1'b1, 1'b0, 0, 6'h00, 6'h00, 1'b0, 2'd3, 1'b0, 1'b1, 6'h12, 5'd1, 5'd1};
        tbl[10] = '{1'b1, 1'b0, 0, 6'h00, 6'h00, 1'b0, 2'd2, 1'b0, 1'b0, 6'h12, 5'd1, 5'd1};
        tbl[11] = '{1'b1, 1'b0, 0, 6'h00, 6'h00, 1'b0, 2'd2, 1'b0, 1'b0, 6'h12, 5'd1, 5'd1};

        clk = 1'b0;
        reset = 1'b1;
        init = 1'b1;
        empty_fifo_VC0 = 1'b1;
        empty_fifo_VC1 = 1'b1;
        data_out_VC0 = 6'h00;
        data_out_VC1 = 6'h00;
        almost_full_D0 = 1'b0;
        almost_full_D1 = 1'b0;
        model_reset();
        #1 reset = 1'b0;
        @(negedge clk);

        // Reset, init, first VC0 transfer to D0 then D1.
        for (int i = 0; i < 12; i++) begin
            reset = tbl[i].rst;
            init  = tbl[i].ini;
            if (tbl[i].nadd > 0) q0.push_back(tbl[i].w0);
            if (tbl[i].nadd > 1) q0.push_back(tbl[i].w1);
            cycle();
            check($sformatf("vec%0d_pop0", i), obs_pop0, tbl[i].e_pop0);
            check($sformatf("vec%0d_state", i), state, tbl[i].e_st);
            check($sformatf("vec%0d_idle", i), idle, (tbl[i].e_st == 2'd2));
            check($sformatf("vec%0d_pushD0", i), push_D0, tbl[i].e_p0);
            check($sformatf("vec%0d_pushD1", i), push_D1, tbl[i].e_p1);
            check($sformatf("vec%0d_data", i), data_out, tbl[i].e_d);
            check($sformatf("vec%0d_cntD0", i), count_D0, tbl[i].e_c0);
            check($sformatf("vec%0d_cntD1", i), count_D1, tbl[i].e_c1);
        end

        // Both VCs loaded: VC0 word first, VC1 word (bit4=0) lands in D0.
        q0.push_back(6'h03);
        q1.push_back(6'h21);
        for (int i = 0; i < 8; i++) begin
            cycle();
            if (push_D0 || push_D1) begin
                words.push_back(data_out);
                dests.push_back(push_D1);
            end
        end
        check("prio_npush", words.size(), 2);
        if (words.size() == 2) begin
            check("prio_first", words[0], 6'h03);
            check("prio_second", words[1], 6'h21);
            check("prio_dest2", dests[1], 1'b0);
        end
        run_until_idle(20);

        // Backpressure: only the in-flight word completes while paused.
        for (int i = 0; i < 10; i++) q0.push_back(6'($urandom));
        repeat (3) cycle();
        almost_full_D1 = 1'b1;
        npop = 0;
        npush = 0;
        for (int i = 0; i < 4; i++) begin
            cycle();
            npop  += int'(obs_pop0 | obs_pop1);
            npush += int'(push_D0 | push_D1);
        end
        check("pause_pops", npop, 0);
        check("pause_inflight_push", npush, 1);
        almost_full_D1 = 1'b0;
        cycle();
        check("pause_resume_pop", obs_pop0, 1'b1);
        run_until_idle(40);

        // Reset while a word is in flight: counters clear at once.
        q0.push_back(6'h15);
        q0.push_back(6'h05);
        q0.push_back(6'h2A);
        repeat (2) cycle();
        reset = 1'b0;
        #1;
        model_reset();
        check("arst_state", state, 2'd0);
        check("arst_cntD0", count_D0, 5'd0);
        check("arst_cntD1", count_D1, 5'd0);
        check("arst_push", {push_D0, push_D1}, 2'b00);
        check("arst_idle", idle, 1'b0);
        q0.delete();
        q1.delete();
        @(negedge clk);
        reinit();
        check("reinit_idle", state, 2'd2);

        // 33 words to D0: counter wraps to 1.
        for (int i = 0; i < 33; i++) q0.push_back(6'($urandom) & 6'h2F);
        run_until_idle(100);
        check("wrap_cntD0", count_D0, 5'd1);
        check("wrap_cntD1", count_D1, 5'd0);

        // Randomized traffic, backpressure and init.
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 2) == 0) q0.push_back(6'($urandom));
            if ($urandom_range(0, 2) == 0) q1.push_back(6'($urandom));
            almost_full_D0 = ($urandom_range(0, 7) == 0);
            almost_full_D1 = ($urandom_range(0, 7) == 0);
            init = ($urandom_range(0, 24) == 0);
            cycle();
        end
        almost_full_D0 = 1'b0;
        almost_full_D1 = 1'b0;
        init = 1'b0;
        run_until_idle(600);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/final_logic.md
Name: final_logic

Overview:
- Read/egress end of the transmission-layer virtual-channel path.
- Drains the VC0/VC1 FIFOs that the ingress logic fills, arbitrates between them with VC0 at strict priority, and routes each word to destination FIFO D0 or D1 according to data bit 4.
- Honours downstream almost-full backpressure.
- Keeps per-destination word counters and an idle flag for the transmission-layer controller.

Parameters:
data_width, 6, word width on the VC FIFO outputs and the destination push bus
count_width, 5, width of the per-destination word counters

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  asynchronous, active-low reset; 0 = in reset
init  input  1  1 = hold or return the block to INIT (no new pops)
empty_fifo_VC0  input  1  VC0 FIFO empty
empty_fifo_VC1  input  1  VC1 FIFO empty
data_out_VC0  input  data_width  VC0 FIFO read data; valid the cycle after pop
data_out_VC1  input  data_width  VC1 FIFO read data; valid the cycle after pop
almost_full_D0  input  1  destination FIFO D0 almost full
almost_full_D1  input  1  destination FIFO D1 almost full
pop_VC0_fifo  output  1  pop request to VC0 FIFO (combinational)
pop_VC1_fifo  output  1  pop request to VC1 FIFO (combinational)
data_out  output  data_width  word pushed to the destination FIFOs (registered)
push_D0  output  1  write strobe for D0 (registered)
push_D1  output  1  write strobe for D1 (registered)
count_D0  output  count_width  words pushed to D0, wraps at 2^count_width
count_D1  output  count_width  words pushed to D1, wraps at 2^count_width
idle  output  1  1 in IDLE state (registered)
state  output  2  current FSM state: RESET=0, INIT=1, IDLE=2, ACTIVE=3

Behaviour:
Reset (reset=0, asynchronous):
- state=RESET.
- data_out=0, push_D0=0, push_D1=0, count_D0=0, count_D1=0, idle=0.
- Pops are 0.
- In-flight pipeline registers (rd_valid, rd_src) are cleared.

FSM, evaluated at each rising edge:
- RESET -> INIT on the first edge with reset=1.
- INIT -> IDLE when init=0 and the pipeline is empty; otherwise stay in INIT.
- IDLE -> ACTIVE when either VC FIFO is non-empty; IDLE -> INIT when init=1.
- ACTIVE -> IDLE when both FIFOs are empty, no pop is issued this cycle, and rd_valid=0.
- ACTIVE -> INIT when init=1. In-flight words still complete their push.

Pause:
- pause = almost_full_D0 | almost_full_D1.
- Conservative: the destination of a word is unknown before it is read.

Pop decision (combinational, only in ACTIVE with init=0 and pause=0):
- pop_VC0_fifo = !empty_fifo_VC0.
- pop_VC1_fifo = empty_fifo_VC0 & !empty_fifo_VC1.
- At most one pop per cycle. VC0 has strict priority; VC1 can starve while VC0 is non-empty, and this is intended.

Pipeline and latency:
- Edge ending pop cycle N: rd_valid<=1 and rd_src<=popped VC; otherwise rd_valid<=0.
- Edge ending cycle N+1 (rd_valid=1): capture w = the selected data_out_VCx into data_out.
  - push_D0<=!w[4], push_D1<=w[4].
  - The matching counter increments by 1 modulo 2^count_width.
- Pop-to-push latency is 2 edges. Sustained throughput is 1 word per cycle.
- With no capture that cycle: push_D0=push_D1=0 and data_out holds its last value.
- Pause does not cancel a word already popped; it is always pushed. The almost-full margin must be at least 2.

Boundary conditions:
- Both FIFOs empty in ACTIVE: no pop, drain, then go to IDLE.
- Simultaneous init=1 and a non-empty FIFO: init wins and no pop is issued.
- Reset mid-transfer: the in-flight word is discarded and counters are cleared.

Test Plan:
1. Reset low 3 cycles, then high with init=1 for 2 cycles, then init=0 -> states RESET, INIT, then IDLE; all outputs 0, idle=1.
2. VC0 holds 0x01, 0x12 -> pops in consecutive ACTIVE cycles; 2 edges later push_D0 with 0x01, then push_D1 with 0x12 (bit4=1); count_D0=1, count_D1=1; returns to IDLE.
3. Both FIFOs non-empty (VC0: 0x03, VC1: 0x21) -> VC0 popped first and 0x03 pushed first; VC1 popped only after empty_fifo_VC0=1; 0x21 goes to D0.
4. almost_full_D1=1 during a stream -> no new pops from the next cycle; the one in-flight word is still pushed; pops resume the cycle after almost_full_D1=0.
5. 33 words with bit4=0 -> count_D0 wraps to 1; count_D1 stays 0.
6. reset=0 asserted while rd_valid=1 -> no push occurs; counters are 0 immediately (asynchronous); state=RESET.
